rv_exec_unit: RTL and testbench
===============================

Name: rv_exec_unit

Overview:
RV32I execute-side datapath slice for the single-cycle core. Contains three parts:
- a 32x32 register file with two read ports and one write port;
- a 5-bit-opcode ALU with an embedded barrel shifter;
- a load/store data aligner that converts byte/half/word accesses into word-addressed memory transactions with byte strobes.

It sits between the instruction decoder and the data memory.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
RF_DEPTH, 32, number of architectural registers; index width is 5.

Ports:
CLK  in  1  clock; the RF writes on the rising edge.
RST  in  1  asynchronous, active-high reset.
RNUM1  in  5  RF read port 1 index.
RNUM2  in  5  RF read port 2 index.
RDATA1  out  32  RF read data 1 (combinational).
RDATA2  out  32  RF read data 2 (combinational).
WNUM  in  5  RF write index; 0 means no write.
WDATA  in  32  RF write data.
ALU_C  in  5  ALU operation code.
ALU_A  in  32  ALU operand A.
ALU_B  in  32  ALU operand B.
ALU_Y  out  32  ALU/shifter result.
ADDRI  in  32  data byte address.
DATAI  in  32  store data (right-justified).
DATAO  out  32  aligned and extended load result.
WE  in  2  store size: 00 none, 01 byte, 10 half, 11 word.
RE  in  2  load size: 00 none, 01 byte, 10 half, 11 word.
SE  in  1  1 = sign-extend load, 0 = zero-extend load.
MADDR  out  30  memory word address; always ADDRI[31:2].
MDATAO  out  32  memory write data.
MDATAI  in  32  memory read word.
MWSTB  out  4  memory byte write strobes.

Behaviour:
- RST asserted: all RF entries clear to 0 immediately.
- All other outputs are combinational from inputs and RF state.
- RF write: on posedge CLK with WNUM != 0, reg[WNUM] <= WDATA.
- Register x0 always reads 0; a write to x0 is discarded.
- RF reads have no bypass: reading a register written in the same cycle returns the old value until after the edge.
- ALU opcodes (Y is 32 bits):
  - IADD 00000: A+B, mod 2^32.
  - ISUB 00001: A-B, mod 2^32.
  - IAND 00010, IOR 00011, IXOR 00100: bitwise operations.
  - IPAS 00101: Y = B.
- Compare opcodes produce Y = {31'b0, cond}:
  - IEQ 01000, INE 01001.
  - ILT 01010 and IGE 01011: signed.
  - ILTU 01100 and IGEU 01101: unsigned.
- Shift opcodes; the shift amount is B[4:0] and B[31:5] is ignored:
  - ISLL 10000: logical left.
  - ISRL 10001: logical right.
  - ISRA 10010: arithmetic right.
- Shifter result is selected when ALU_C[4:2] == 3'b100. Any undefined code gives Y = 0.
- Byte lanes are little-endian: byte offset k maps to MDATAI/MDATAO bits [8k+7:8k].
- Store strobes and write data:
  - WE=01: MWSTB = 1 << ADDRI[1:0]; MDATAO = DATAI[7:0] replicated in all 4 lanes.
  - WE=10: MWSTB = 0011 if ADDRI[1]=0, else 1100; MDATAO = DATAI[15:0] in both halves.
  - WE=11: MWSTB = 1111; MDATAO = DATAI.
  - WE=00: MWSTB = 0000; MDATAO = DATAI.
- Load alignment:
  - RE=01: byte at lane ADDRI[1:0], extended per SE.
  - RE=10: half selected by ADDRI[1], extended per SE.
  - RE=11: full word.
  - RE=00: DATAO = 0.
- Misaligned accesses are not trapped. Halfword accesses ignore ADDRI[0]; word accesses ignore ADDRI[1:0].
- If WE and RE are both nonzero, the store path and load path operate independently.
- Reset during operation clears the RF asynchronously and leaves combinational paths unaffected.

Optional Feature:
Macro: MISALIGN_DET_EN.
- Defined: adds output MISALIGN (1 bit, combinational). It is 1 when (WE or RE is a halfword and ADDRI[0]=1) or (WE or RE is a word and ADDRI[1:0] != 0). When it is 1, MWSTB is forced to 0000.
- Undefined: no MISALIGN port exists; behaviour is as described above.

Decomposition:
- Shared package holds:
  - the 5-bit ALU opcode constants (IADD … ISRA);
  - the size encodings for WE/RE (none/byte/half/word);
  - the XLEN constant.
- One natural sub-module, exec_shifter, implements the combinational 32-bit shifter (SLL/SRL/SRA), instantiated inside the ALU path.
- RF and aligner stay inline.

Test Plan:
- Assert RST, then read regs 1..31 → all 0. Write x5 = 0xDEADBEEF with WNUM=5, then read after the edge → 0xDEADBEEF. Read in the same cycle as the write → old value 0.
- Write x0 = 0x1234 → RDATA1 with RNUM1=0 stays 0.
- ALU checks:
  - A=0x7FFFFFFF, B=1, IADD → 0x80000000.
  - ISUB with A=0, B=1 → 0xFFFFFFFF.
  - ILT with A=0xFFFFFFFF, B=1 → 1; ILTU on the same operands → 0.
  - ISRA with A=0x80000000, B=0x24 (shift amount 4) → 0xF8000000.
- Store byte: WE=01, ADDRI=0x00100003, DATAI=0x000000AB → MWSTB=1000, MDATAO=0xABABABAB, MADDR=0x00040000.
- Load: MDATAI=0x80FF1234.
  - RE=01, ADDRI[1:0]=2, SE=1 → 0xFFFFFFFF.
  - RE=10, ADDRI[1]=1, SE=0 → 0x000080FF.
  - RE=10, ADDRI[1]=1, SE=1 → 0xFFFF80FF.
  - RE=11 → 0x80FF1234.
- With MISALIGN_DET_EN defined: WE=11, ADDRI=0x2 → MISALIGN=1 and MWSTB=0000.

Source files
------------

// File: rtl/rv_exec_unit_pkg.sv
// Shared constants for the rv_exec_unit execute slice.
// ALU opcodes, access-size encodings and datapath width.
package rv_exec_unit_pkg;

    localparam int XLEN     = 32;
    localparam int RF_DEPTH = 32;

    localparam logic [4:0] IADD = 5'b00000;
    localparam logic [4:0] ISUB = 5'b00001;
    localparam logic [4:0] IAND = 5'b00010;
    localparam logic [4:0] IOR  = 5'b00011;
    localparam logic [4:0] IXOR = 5'b00100;
    localparam logic [4:0] IPAS = 5'b00101;
    localparam logic [4:0] IEQ  = 5'b01000;
    localparam logic [4:0] INE  = 5'b01001;
    localparam logic [4:0] ILT  = 5'b01010;
    localparam logic [4:0] IGE  = 5'b01011;
    localparam logic [4:0] ILTU = 5'b01100;
    localparam logic [4:0] IGEU = 5'b01101;
    localparam logic [4:0] ISLL = 5'b10000;
    localparam logic [4:0] ISRL = 5'b10001;
    localparam logic [4:0] ISRA = 5'b10010;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

endpackage

// File: rtl/rv_exec_unit_exec_shifter.sv
// Combinational 32-bit barrel shifter (SLL/SRL/SRA).
// op is the low two bits of the shift opcode; 2'b11 yields 0.
module exec_shifter
    import rv_exec_unit_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [4:0]      shamt,
    input  logic [1:0]      op,
    output logic [XLEN-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            2'b00:   y = a << shamt;
            2'b01:   y = a >> shamt;
            2'b10:   y = $unsigned($signed(a) >>> shamt);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rv_exec_unit.sv
// RV32I execute slice: register file, ALU with shifter, load/store aligner.
// Optional MISALIGN output and strobe suppression with MISALIGN_DET_EN.
module rv_exec_unit
    import rv_exec_unit_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic [4:0]      RNUM1,
    input  logic [4:0]      RNUM2,
    output logic [XLEN-1:0] RDATA1,
    output logic [XLEN-1:0] RDATA2,
    input  logic [4:0]      WNUM,
    input  logic [XLEN-1:0] WDATA,
    input  logic [4:0]      ALU_C,
    input  logic [XLEN-1:0] ALU_A,
    input  logic [XLEN-1:0] ALU_B,
    output logic [XLEN-1:0] ALU_Y,
    input  logic [XLEN-1:0] ADDRI,
    input  logic [XLEN-1:0] DATAI,
    output logic [XLEN-1:0] DATAO,
    input  logic [1:0]      WE,
    input  logic [1:0]      RE,
    input  logic            SE,
    output logic [29:0]     MADDR,
    output logic [XLEN-1:0] MDATAO,
    input  logic [XLEN-1:0] MDATAI,
    output logic [3:0]      MWSTB
`ifdef MISALIGN_DET_EN
   ,output logic            MISALIGN
`endif
);

    logic [XLEN-1:0] rf [RF_DEPTH];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < RF_DEPTH; i++)
                rf[i] <= '0;
        end else if (WNUM != 5'd0) begin
            rf[WNUM] <= WDATA;
        end
    end

    assign RDATA1 = (RNUM1 == 5'd0) ? '0 : rf[RNUM1];
    assign RDATA2 = (RNUM2 == 5'd0) ? '0 : rf[RNUM2];

    logic [XLEN-1:0] sh_y;

    exec_shifter u_shifter (
        .a     (ALU_A),
        .shamt (ALU_B[4:0]),
        .op    (ALU_C[1:0]),
        .y     (sh_y)
    );

    always_comb begin
        ALU_Y = '0;
        if (ALU_C[4:2] == 3'b100) begin
            ALU_Y = sh_y;
        end else begin
            case (ALU_C)
                IADD:    ALU_Y = ALU_A + ALU_B;
                ISUB:    ALU_Y = ALU_A - ALU_B;
                IAND:    ALU_Y = ALU_A & ALU_B;
                IOR:     ALU_Y = ALU_A | ALU_B;
                IXOR:    ALU_Y = ALU_A ^ ALU_B;
                IPAS:    ALU_Y = ALU_B;
                IEQ:     ALU_Y = {31'b0, ALU_A == ALU_B};
                INE:     ALU_Y = {31'b0, ALU_A != ALU_B};
                ILT:     ALU_Y = {31'b0, $signed(ALU_A) < $signed(ALU_B)};
                IGE:     ALU_Y = {31'b0, $signed(ALU_A) >= $signed(ALU_B)};
                ILTU:    ALU_Y = {31'b0, ALU_A < ALU_B};
                IGEU:    ALU_Y = {31'b0, ALU_A >= ALU_B};
                default: ALU_Y = '0;
            endcase
        end
    end

    assign MADDR = ADDRI[31:2];

    logic [3:0] stb;

    always_comb begin
        stb    = 4'b0000;
        MDATAO = DATAI;
        case (WE)
            SZ_BYTE: begin
                stb    = 4'b0001 << ADDRI[1:0];
                MDATAO = {4{DATAI[7:0]}};
            end
            SZ_HALF: begin
                stb    = ADDRI[1] ? 4'b1100 : 4'b0011;
                MDATAO = {2{DATAI[15:0]}};
            end
            SZ_WORD: stb = 4'b1111;
            default: stb = 4'b0000;
        endcase
    end

`ifdef MISALIGN_DET_EN
    logic any_half;
    logic any_word;

    assign any_half = (WE == SZ_HALF) || (RE == SZ_HALF);
    assign any_word = (WE == SZ_WORD) || (RE == SZ_WORD);
    assign MISALIGN = (any_half && ADDRI[0]) ||
                      (any_word && (ADDRI[1:0] != 2'b00));
    assign MWSTB    = MISALIGN ? 4'b0000 : stb;
`else
    assign MWSTB    = stb;
`endif

    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    assign ld_b = MDATAI[{ADDRI[1:0], 3'b000} +: 8];
    assign ld_h = ADDRI[1] ? MDATAI[31:16] : MDATAI[15:0];

    always_comb begin
        DATAO = '0;
        case (RE)
            SZ_BYTE: DATAO = {{24{SE & ld_b[7]}}, ld_b};
            SZ_HALF: DATAO = {{16{SE & ld_h[15]}}, ld_h};
            SZ_WORD: DATAO = MDATAI;
            default: DATAO = '0;
        endcase
    end

endmodule

// File: tb/tb_rv_exec_unit.sv
// Self-checking bench for rv_exec_unit: directed steps plus random
// vectors against an arithmetic reference model.
module tb_rv_exec_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  RNUM1, RNUM2, WNUM, ALU_C;
    logic [31:0] RDATA1, RDATA2, WDATA, ALU_A, ALU_B, ALU_Y;
    logic [31:0] ADDRI, DATAI, DATAO, MDATAO, MDATAI;
    logic [1:0]  WE, RE;
    logic        SE;
    logic [29:0] MADDR;
    logic [3:0]  MWSTB;
`ifdef MISALIGN_DET_EN
    logic        MISALIGN;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] m_rf [32];

    rv_exec_unit dut (
        .CLK(CLK), .RST(RST),
        .RNUM1(RNUM1), .RNUM2(RNUM2),
        .RDATA1(RDATA1), .RDATA2(RDATA2),
        .WNUM(WNUM), .WDATA(WDATA),
        .ALU_C(ALU_C), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Y(ALU_Y),
        .ADDRI(ADDRI), .DATAI(DATAI), .DATAO(DATAO),
        .WE(WE), .RE(RE), .SE(SE),
        .MADDR(MADDR), .MDATAO(MDATAO), .MDATAI(MDATAI), .MWSTB(MWSTB)
`ifdef MISALIGN_DET_EN
       ,.MISALIGN(MISALIGN)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [4:0] c,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int s;
        s = int'(b % 32);
        case (c)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a & b;
            5'd3:  return a | b;
            5'd4:  return a ^ b;
            5'd5:  return b;
            5'd8:  return (a == b) ? 32'd1 : 32'd0;
            5'd9:  return (a != b) ? 32'd1 : 32'd0;
            5'd10: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            5'd11: return (int'(a) >= int'(b)) ? 32'd1 : 32'd0;
            5'd12: return (a < b) ? 32'd1 : 32'd0;
            5'd13: return (a >= b) ? 32'd1 : 32'd0;
            5'd16: return 32'((64'(a) * (64'd1 << s)) % 64'h1_0000_0000);
            5'd17: return a / (32'd1 << s);
            5'd18: return 32'(int'(a) >>> s);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_mis(input logic [1:0] we,
                                     input logic [1:0] re,
                                     input logic [31:0] addr);
        logic h, w;
        h = (we == 2'd2) || (re == 2'd2);
        w = (we == 2'd3) || (re == 2'd3);
        return (h && (addr % 2 != 0)) || (w && (addr % 4 != 0));
    endfunction

    function automatic logic [31:0] ref_stb(input logic [1:0] we,
                                            input logic [31:0] addr);
        logic [31:0] s;
        case (we)
            2'd1: s = 32'd1 << (addr % 4);
            2'd2: s = (addr % 4 >= 2) ? 32'hC : 32'h3;
            2'd3: s = 32'hF;
            default: s = 32'h0;
        endcase
`ifdef MISALIGN_DET_EN
        if (ref_mis(we, 2'd0, addr) || ref_mis(2'd0, RE, addr)) s = 0;
`endif
        return s;
    endfunction

    function automatic logic [31:0] ref_wdat(input logic [1:0] we,
                                             input logic [31:0] d);
        case (we)
            2'd1: return (d % 256) * 32'h0101_0101;
            2'd2: return (d % 65536) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] re,
                                             input logic se,
                                             input logic [31:0] addr,
                                             input logic [31:0] mi);
        logic [31:0] v;
        int off;
        off = int'(addr % 4);
        case (re)
            2'd1: begin
                v = (mi >> (8 * off)) % 256;
                if (se && v >= 128) v = v + 32'hFFFF_FF00;
            end
            2'd2: begin
                v = (off >= 2) ? mi / 65536 : mi % 65536;
                if (se && v >= 32768) v = v + 32'hFFFF_0000;
            end
            2'd3: v = mi;
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic chk_all(input string tag);
        chk({tag, "_rd1"}, RDATA1, m_rf[RNUM1]);
        chk({tag, "_rd2"}, RDATA2, m_rf[RNUM2]);
        chk({tag, "_alu"}, ALU_Y, ref_alu(ALU_C, ALU_A, ALU_B));
        chk({tag, "_maddr"}, {2'b00, MADDR}, ADDRI / 4);
        chk({tag, "_stb"}, {28'd0, MWSTB}, ref_stb(WE, ADDRI));
        chk({tag, "_mdo"}, MDATAO, ref_wdat(WE, DATAI));
        chk({tag, "_load"}, DATAO, ref_load(RE, SE, ADDRI, MDATAI));
`ifdef MISALIGN_DET_EN
        chk({tag, "_mis"}, {31'd0, MISALIGN},
            {31'd0, ref_mis(WE, RE, ADDRI)});
`endif
    endtask

    logic [4:0] codes [15] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5,
                               5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13,
                               5'd16, 5'd17, 5'd18};

    initial begin
        RST = 1'b1;
        RNUM1 = 0; RNUM2 = 0; WNUM = 0; WDATA = 0;
        ALU_C = 0; ALU_A = 0; ALU_B = 0;
        ADDRI = 0; DATAI = 0; MDATAI = 0;
        WE = 0; RE = 0; SE = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        for (int r = 1; r < 32; r++) begin
            RNUM1 = 5'(r);
            #1 chk("reset_rf", RDATA1, 32'h0);
        end

        @(negedge CLK);
        WNUM = 5; WDATA = 32'hDEAD_BEEF; RNUM1 = 5;
        #1 chk("same_cycle_old", RDATA1, 32'h0);
        @(posedge CLK);
        #1 chk("x5_written", RDATA1, 32'hDEAD_BEEF);
        m_rf[5] = 32'hDEAD_BEEF;

        @(negedge CLK);
        WNUM = 0; WDATA = 32'h1234; RNUM1 = 0;
        @(posedge CLK);
        #1 chk("x0_discard", RDATA1, 32'h0);

        @(negedge CLK);
        WNUM = 0;
        ALU_C = 5'b00000; ALU_A = 32'h7FFF_FFFF; ALU_B = 1;
        #1 chk("iadd_ovf", ALU_Y, 32'h8000_0000);
        ALU_C = 5'b00001; ALU_A = 0; ALU_B = 1;
        #1 chk("isub_wrap", ALU_Y, 32'hFFFF_FFFF);
        ALU_C = 5'b01010; ALU_A = 32'hFFFF_FFFF; ALU_B = 1;
        #1 chk("ilt_signed", ALU_Y, 32'h1);
        ALU_C = 5'b01100;
        #1 chk("iltu_unsigned", ALU_Y, 32'h0);
        ALU_C = 5'b10010; ALU_A = 32'h8000_0000; ALU_B = 32'h24;
        #1 chk("isra_sh4", ALU_Y, 32'hF800_0000);
        ALU_C = 5'b10011;
        #1 chk("undef_10011", ALU_Y, 32'h0);

        WE = 2'b01; ADDRI = 32'h0010_0003; DATAI = 32'hAB;
        #1 chk("sb_stb", {28'd0, MWSTB}, 32'h8);
        chk("sb_data", MDATAO, 32'hABAB_ABAB);
        chk("sb_maddr", {2'b00, MADDR}, 32'h0004_0000);

        WE = 2'b00; MDATAI = 32'h80FF_1234;
        RE = 2'b01; ADDRI = 32'h2; SE = 1;
        #1 chk("lb_sext", DATAO, 32'hFFFF_FFFF);
        RE = 2'b10; ADDRI = 32'h2; SE = 0;
        #1 chk("lhu_hi", DATAO, 32'h0000_80FF);
        SE = 1;
        #1 chk("lh_hi", DATAO, 32'hFFFF_80FF);
        RE = 2'b11; ADDRI = 32'h0;
        #1 chk("lw", DATAO, 32'h80FF_1234);
        RE = 2'b00;
        #1 chk("lnone", DATAO, 32'h0);

`ifdef MISALIGN_DET_EN
        WE = 2'b11; ADDRI = 32'h2;
        #1 chk("mis_flag", {31'd0, MISALIGN}, 32'h1);
        chk("mis_stb", {28'd0, MWSTB}, 32'h0);
        WE = 2'b00;
`endif

        for (int n = 0; n < 400; n++) begin
            @(negedge CLK);
            RNUM1 = 5'($urandom_range(0, 31));
            RNUM2 = 5'($urandom_range(0, 31));
            WNUM  = 5'($urandom_range(0, 31));
            WDATA = $urandom;
            if ($urandom_range(0, 9) < 8)
                ALU_C = codes[$urandom_range(0, 14)];
            else
                ALU_C = 5'($urandom_range(0, 31));
            ALU_A = $urandom;
            ALU_B = ($urandom_range(0, 3) == 0) ? ALU_A : $urandom;
            ADDRI  = $urandom;
            DATAI  = $urandom;
            MDATAI = $urandom;
            WE = 2'($urandom_range(0, 3));
            RE = 2'($urandom_range(0, 3));
            SE = 1'($urandom_range(0, 1));
            #1 chk_all("rand");
            @(posedge CLK);
            if (WNUM != 0) m_rf[WNUM] = WDATA;
        end

        @(negedge CLK);
        WNUM = 7; WDATA = 32'h0BAD_F00D; RNUM1 = 7; RNUM2 = 5;
        @(posedge CLK);
        m_rf[7] = 32'h0BAD_F00D;
        #1 chk("pre_rst_x7", RDATA1, 32'h0BAD_F00D);
        WNUM = 0;
        ALU_C = 5'b00000; ALU_A = 32'h10; ALU_B = 32'h22;
        #2 RST = 1'b1;
        #1 chk("async_rst_x7", RDATA1, 32'h0);
        chk("async_rst_x5", RDATA2, 32'h0);
        chk("rst_alu_live", ALU_Y, 32'h32);
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
        @(negedge CLK);
        RST = 1'b0;
        #1 chk_all("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
